// File: rtl/ttl_pkg.sv
// Shared definitions for the clocked TTL chip models of the Pong netlist.
// Mode select codes follow the 74LS194 S1:S0 pin pair.
package ttl_pkg;

   typedef logic [1:0] mode_t;

   localparam mode_t MODE_HOLD = 2'b00;
   localparam mode_t MODE_SR   = 2'b01;
   localparam mode_t MODE_SL   = 2'b10;
   localparam mode_t MODE_LOAD = 2'b11;

endpackage

// File: rtl/ttl_edge_det.sv
// Synchroniser plus rising-edge detector for a TTL chip clock pin sampled by
// the system clock. edge_o is the combinational pulse, rise_o its registered copy.
module ttl_edge_det #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic edge_o,
   output logic rise_o
);

   logic [STAGES-1:0] sync_q;
   logic [STAGES-1:0] vld_q;
   logic              hist_q;
   logic              armed_q;
   logic              rise_q;
   logic              sync_out;

   assign sync_out = sync_q[STAGES-1];
   // A high pin seen straight out of reset is not an edge: the detector only
   // arms once a genuine low sample has travelled through the synchroniser.
   assign edge_o   = sync_out & ~hist_q & armed_q;
   assign rise_o   = rise_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q  <= '0;
         vld_q   <= '0;
         hist_q  <= 1'b0;
         armed_q <= 1'b0;
         rise_q  <= 1'b0;
      end else begin
         sync_q[0] <= d_i;
         vld_q[0]  <= 1'b1;
         for (int i = 1; i < int'(STAGES); i++) begin
            sync_q[i] <= sync_q[i-1];
            vld_q[i]  <= vld_q[i-1];
         end
         hist_q  <= sync_out;
         armed_q <= armed_q | (vld_q[STAGES-1] & ~sync_out);
         rise_q  <= edge_o;
      end
   end

endmodule

// File: rtl/ls194_shift.sv
// 74LS194 4-bit bidirectional universal shift register on the system clock.
// LS194_PIN_CLOCK_EN defined: cp is edge-detected; undefined: cp is a clock enable.
module ls194_shift
   import ttl_pkg::*;
#(
   parameter int unsigned WIDTH          = 4,
   parameter int unsigned CP_SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             mr_n,
   input  logic             cp,
   input  logic             s0,
   input  logic             s1,
   input  logic             dsr,
   input  logic             dsl,
   input  logic [WIDTH-1:0] p,
   output logic [WIDTH-1:0] q,
   output logic             cp_rise
);

   if (CP_SYNC_STAGES < 1 || CP_SYNC_STAGES > 3) begin : g_bad_stages
      $error("ls194_shift: CP_SYNC_STAGES must be 1..3");
   end

   logic             adv;
   mode_t            mode;
   logic [WIDTH-1:0] q_d;
   logic [WIDTH-1:0] q_q;

`ifdef LS194_PIN_CLOCK_EN
   ttl_edge_det #(
      .STAGES (CP_SYNC_STAGES)
   ) u_cp_edge (
      .clk    (clk),
      .rst_n  (rst_n),
      .d_i    (cp),
      .edge_o (adv),
      .rise_o (cp_rise)
   );
`else
   logic cp_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cp_q <= 1'b0;
      else        cp_q <= cp;
   end

   assign adv     = cp;
   assign cp_rise = cp_q;
`endif

   assign mode = {s1, s0};

   // Chip master reset outranks any clock edge landing on the same cycle.
   always_comb begin
      q_d = q_q;
      if (!mr_n) begin
         q_d = '0;
      end else if (adv) begin
         case (mode)
            MODE_SR:   q_d = {q_q[WIDTH-2:0], dsr};
            MODE_SL:   q_d = {dsl, q_q[WIDTH-1:1]};
            MODE_LOAD: q_d = p;
            default:   q_d = q_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) q_q <= '0;
      else        q_q <= q_d;
   end

   assign q = q_q;

endmodule
